// File: rtl/led_timer_pkg.sv
// Shared types and helpers for the scheduled LED/interval timer.
// Provides the FSM state type and the round-robin pick function used by rr_arbiter.
package led_timer_pkg;

    localparam int unsigned MAX_N = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } led_timer_state_t;

    // First set bit of req at or after ptr, wrapping modulo n; returns ptr if req is empty.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_N-1:0] req,
                                                 input logic [IDX_W-1:0] ptr,
                                                 input int unsigned      n);
        logic [IDX_W-1:0] win;
        logic             found;
        int unsigned      idx;
        win   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx = (32'(ptr) + k) % n;
                if (!found && req[IDX_W'(idx)]) begin
                    win   = IDX_W'(idx);
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for led_timer_sched.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   eligible[N]     requests allowed to win this cycle
//   complete        strobe: service of owner finished, advance pointer past it
//   owner           index of the channel that just finished
//   winner_c        combinational winning index (valid only when valid_c)
//   valid_c         combinational: some eligible request exists
module rr_arbiter
    import led_timer_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     eligible,
    input  logic             complete,
    input  logic [IDX_W-1:0] owner,
    output logic [IDX_W-1:0] winner_c,
    output logic             valid_c
);

    logic [IDX_W-1:0] rr_ptr;

    // Search always starts at the channel after the most recently serviced one.
    assign winner_c = rr_pick(MAX_N'(eligible), rr_ptr, N);
    assign valid_c  = |eligible;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (complete) begin
            rr_ptr <= (owner == IDX_W'(N - 1)) ? '0 : owner + IDX_W'(1);
        end
    end

endmodule

// File: rtl/led_timer_sched.sv
// led_timer_sched: one down-counter shared round-robin between N interval requesters.
// Each completed interval pulses that channel's done and toggles its LED.
// Ports:
//   clk            sole clock
//   rst            synchronous active-high reset
//   req[N]         level requests, held until gnt seen
//   dur[N*CNT_W]   per-channel durations, sampled at grant
//   gnt[N]         one-hot grant for the whole service
//   done[N]        one-cycle completion pulse
//   led[N]         per-channel toggle output
//   busy           high while servicing
// Optional build macro LED_TIMER_PRESCALE_EN: count decrements once every
// 2^PRESCALE_LOG2 cycles instead of every cycle.
module led_timer_sched
    import led_timer_pkg::*;
#(
    parameter int unsigned N             = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned PRESCALE_LOG2 = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       req,
    input  logic [N*CNT_W-1:0] dur,
    output logic [N-1:0]       gnt,
    output logic [N-1:0]       done,
    output logic [N-1:0]       led,
    output logic               busy
);

    led_timer_state_t state, state_nx;
    logic [CNT_W-1:0] count, count_nx, dur_sel_c;
    logic [IDX_W-1:0] owner, owner_nx, winner_c;
    logic [N-1:0]     gnt_nx, done_nx, led_nx, eligible_c;
    logic             busy_nx, valid_c, grant_c, complete_c, tick_c;

    // A channel pulsing done this cycle must not be re-granted immediately.
    assign eligible_c = req & ~done;

    rr_arbiter #(.N(N)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .eligible (eligible_c),
        .complete (complete_c),
        .owner    (owner),
        .winner_c (winner_c),
        .valid_c  (valid_c)
    );

`ifdef LED_TIMER_PRESCALE_EN
    logic [PRESCALE_LOG2-1:0] presc;

    // Restarted at grant so every tick period is a full 2^PRESCALE_LOG2 cycles.
    always_ff @(posedge clk) begin
        if (rst || grant_c) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESCALE_LOG2'(1);
        end
    end

    assign tick_c = &presc;
`else
    logic unused_presc;
    assign unused_presc = |32'(PRESCALE_LOG2);
    assign tick_c       = 1'b1;
`endif

    // Duration mux for the arbitration winner.
    always_comb begin
        dur_sel_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (winner_c == IDX_W'(i)) begin
                dur_sel_c = dur[i*CNT_W +: CNT_W];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        owner_nx   = owner;
        gnt_nx     = gnt;
        busy_nx    = busy;
        led_nx     = led;
        done_nx    = '0;
        grant_c    = 1'b0;
        complete_c = 1'b0;
        case (state)
            IDLE: begin
                if (valid_c) begin
                    state_nx = RUN;
                    owner_nx = winner_c;
                    count_nx = dur_sel_c;
                    busy_nx  = 1'b1;
                    grant_c  = 1'b1;
                    for (int unsigned i = 0; i < N; i++) begin
                        gnt_nx[i] = (winner_c == IDX_W'(i));
                    end
                end
            end
            RUN: begin
                if (count == '0) begin
                    state_nx   = IDLE;
                    gnt_nx     = '0;
                    busy_nx    = 1'b0;
                    done_nx    = gnt;
                    led_nx     = led ^ gnt;
                    complete_c = 1'b1;
                end else if (tick_c) begin
                    count_nx = count - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            owner <= '0;
            gnt   <= '0;
            done  <= '0;
            led   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            owner <= owner_nx;
            gnt   <= gnt_nx;
            done  <= done_nx;
            led   <= led_nx;
            busy  <= busy_nx;
        end
    end

endmodule

// File: tb/tb_led_timer_sched.sv
// Directed self-checking bench for led_timer_sched (N=4, CNT_W=16, PRESCALE_LOG2=4).
// Expected completions (channel, relative cycle) are queued when stimulus is
// applied and popped when a done pulse appears.
module tb_led_timer_sched;

    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 16;

    typedef struct {
        int ch;
        int cyc;
    } sb_t;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*CNT_W-1:0] dur;
    logic [N-1:0]     gnt, done, led;
    logic             busy;

    int  cyc   = 0;
    int  base  = 0;
    int  total = 0;
    int  bad   = 0;
    logic [N-1:0] led_exp;
    sb_t sb[$];

    led_timer_sched #(.N(N), .CNT_W(CNT_W), .PRESCALE_LOG2(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dur  (dur),
        .gnt  (gnt),
        .done (done),
        .led  (led),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "bench time limit reached");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int ch, input int c);
        sb_t e;
        e.ch  = ch;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        dur = '0;
        @(negedge clk);
        chk("rst_gnt",  32'(gnt),  32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_led",  32'(led),  32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        rst     = 1'b0;
        led_exp = '0;
        sb.delete();
    endtask

    task automatic advance_to(input int rel);
        while (cyc - base < rel) @(negedge clk);
    endtask

    // Wait (bounded) for the next done pulse and compare against the scoreboard head.
    task automatic wait_done(input int budget);
        sb_t e;
        bit  seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
            if (done != '0) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'(1));
        if (seen && sb.size() != 0) begin
            e = sb.pop_front();
            led_exp = led_exp ^ N'(1 << e.ch);
            chk("done_vec",     32'(done),       32'(1 << e.ch));
            chk("done_cyc",     32'(cyc - base), 32'(e.cyc));
            chk("led_at_done",  32'(led),        32'(led_exp));
            chk("busy_at_done", 32'(busy),       32'(0));
            chk("gnt_at_done",  32'(gnt),        32'(0));
        end
    endtask

    initial begin
        int hits;
        rst = 1'b1;
        req = '0;
        dur = '0;

        // 1. Single request on channel 1, dur=5.
        do_reset();
        base = cyc;
        dur[1*CNT_W +: CNT_W] = 16'd5;
        req = 4'b0010;
        push_exp(1, 7);
        @(negedge clk);
        chk("t1_gnt_c1",  32'(gnt),  32'(4'b0010));
        chk("t1_busy_c1", 32'(busy), 32'(1));
        req = '0;
        advance_to(6);
        chk("t1_gnt_c6", 32'(gnt), 32'(4'b0010));
        wait_done(20);

        // 2. Round-robin with all requests held, all durations zero.
        do_reset();
        base = cyc;
        req = 4'b1111;
        push_exp(0, 2);
        push_exp(1, 4);
        push_exp(2, 6);
        push_exp(3, 8);
        push_exp(0, 10);
        for (int k = 0; k < 5; k++) wait_done(10);
        req = '0;
        chk("t2_led_final", 32'(led), 32'(4'b1110));

        // 3. Zero duration on the top channel, pointer wraps to 0.
        do_reset();
        base = cyc;
        req = 4'b1000;
        push_exp(3, 2);
        @(negedge clk);
        chk("t3_gnt_c1", 32'(gnt), 32'(4'b1000));
        req = '0;
        wait_done(10);
        req = 4'b1001;
        push_exp(0, 4);
        @(negedge clk);
        chk("t3_gnt_wrap", 32'(gnt), 32'(4'b0001));
        req = '0;
        wait_done(10);

        // 4. Reset in the middle of a long service.
        do_reset();
        base = cyc;
        dur[0 +: CNT_W] = 16'd100;
        req = 4'b0001;
        @(negedge clk);
        chk("t4_gnt_c1", 32'(gnt), 32'(4'b0001));
        req = '0;
        advance_to(20);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_gnt_rst",  32'(gnt),  32'(0));
        chk("t4_busy_rst", 32'(busy), 32'(0));
        chk("t4_led_rst",  32'(led),  32'(0));
        rst  = 1'b0;
        hits = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done != '0) hits++;
        end
        chk("t4_no_done", 32'(hits), 32'(0));

        // 5. Duration rewritten during service is ignored.
        do_reset();
        base = cyc;
        dur[0 +: CNT_W] = 16'd10;
        req = 4'b0001;
        push_exp(0, 12);
        @(negedge clk);
        req = '0;
        advance_to(3);
        dur[0 +: CNT_W] = 16'd1;
        wait_done(30);

        // 6. dur=3 on channel 2; timing depends on the prescale build option.
        do_reset();
        base = cyc;
        dur[2*CNT_W +: CNT_W] = 16'd3;
        req = 4'b0100;
`ifdef LED_TIMER_PRESCALE_EN
        push_exp(2, 50);
`else
        push_exp(2, 5);
`endif
        @(negedge clk);
        req = '0;
        wait_done(100);
        chk("sb_empty", 32'(sb.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
